// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control constants: operand forward-select encodings and the
// scoreboard entry layout used by the hazard unit and the ID operand muxes.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_EXALU  = 2'b01;
    localparam logic [1:0] FWD_MEMALU = 2'b10;
    localparam logic [1:0] FWD_MEMLD  = 2'b11;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic [4:0] rn;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{wreg: 1'b0, m2reg: 1'b0, rn: 5'd0};

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one ID source register against the EX/MEM scoreboard;
// also flags a load-use conflict with the instruction in EX.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_rn,
    input  logic       mem_wreg,
    input  logic       mem_m2reg,
    input  logic [4:0] mem_rn,
    output logic [1:0] sel,
    output logic       ld_use
);

    logic ex_hit;
    logic mem_hit;

    // r0 is hardwired, so it never matches a producer.
    assign ex_hit  = use_src && (src != 5'd0) && ex_wreg  && (ex_rn  == src);
    assign mem_hit = use_src && (src != 5'd0) && mem_wreg && (mem_rn == src);

    always_comb begin
        sel = FWD_REG;
        if (ex_hit)
            sel = FWD_EXALU;
        else if (mem_hit)
            sel = mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
    end

    assign ld_use = ex_hit && ex_m2reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks EX/MEM destinations, selects operand forwarding
// and inserts a single-cycle bubble on load-use, counting stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic [4:0]  id_rn,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_bubble,
    output logic [15:0] stall_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == STALL_CNT_MAX) ? v : v + 16'd1;
    endfunction

    sb_entry_t ex_p1;
    sb_entry_t mem_p2;
    logic      ld_use_a;
    logic      ld_use_b;
    logic      stall;

    hazard_fwd_sel u_sel_rs (
        .src       (id_rs),
        .use_src   (id_use_rs),
        .ex_wreg   (ex_p1.wreg),
        .ex_m2reg  (ex_p1.m2reg),
        .ex_rn     (ex_p1.rn),
        .mem_wreg  (mem_p2.wreg),
        .mem_m2reg (mem_p2.m2reg),
        .mem_rn    (mem_p2.rn),
        .sel       (fwda),
        .ld_use    (ld_use_a)
    );

    hazard_fwd_sel u_sel_rt (
        .src       (id_rt),
        .use_src   (id_use_rt),
        .ex_wreg   (ex_p1.wreg),
        .ex_m2reg  (ex_p1.m2reg),
        .ex_rn     (ex_p1.rn),
        .mem_wreg  (mem_p2.wreg),
        .mem_m2reg (mem_p2.m2reg),
        .mem_rn    (mem_p2.rn),
        .sel       (fwdb),
        .ld_use    (ld_use_b)
    );

    assign stall       = ld_use_a || ld_use_b;
    assign pc_we       = !stall;
    assign ifid_we     = !stall;
    assign idex_bubble = stall;

    // ID -> EX (p1) -> MEM (p2); a stalled ID instruction enters EX as a NOP.
    always_ff @(posedge clk) begin
        if (clr) begin
            ex_p1     <= SB_EMPTY;
            mem_p2    <= SB_EMPTY;
            stall_cnt <= 16'd0;
        end else begin
            mem_p2 <= ex_p1;
            ex_p1  <= stall ? SB_EMPTY
                            : '{wreg: id_wreg, m2reg: id_m2reg, rn: id_rn};
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random
// instruction streams checked against an instruction-history reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  id_rs, id_rt, id_rn;
    logic        id_use_rs, id_use_rt, id_wreg, id_m2reg;
    logic [1:0]  fwda, fwdb;
    logic        pc_we, ifid_we, idex_bubble;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit       wr;
        bit       ld;
        bit [4:0] dst;
    } instr_t;

    // hist[0] = instruction now in EX, hist[1] = instruction now in MEM
    instr_t hist[$];
    int     m_stalls;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .clr         (clr),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_wreg     (id_wreg),
        .id_m2reg    (id_m2reg),
        .id_rn       (id_rn),
        .fwda        (fwda),
        .fwdb        (fwdb),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .idex_bubble (idex_bubble),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        instr_t nop = '{wr: 0, ld: 0, dst: 0};
        hist = {nop, nop};
        m_stalls = 0;
    endfunction

    // Most recent older instruction writing s decides the source of the value.
    function automatic bit [1:0] ref_fwd(input bit [4:0] s, input bit used);
        if (!used || s == 0) return 2'b00;
        if (hist[0].wr && hist[0].dst == s) return 2'b01;
        if (hist[1].wr && hist[1].dst == s) return hist[1].ld ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_stall(input bit [4:0] rs, rt, input bit urs, urt);
        bit need_rs = urs && rs != 0 && hist[0].wr && hist[0].dst == rs;
        bit need_rt = urt && rt != 0 && hist[0].wr && hist[0].dst == rt;
        return hist[0].ld && (need_rs || need_rt);
    endfunction

    task automatic cycle(input logic c, input logic w, input logic m, input logic [4:0] rn,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt);
        bit     st;
        instr_t ins;
        @(negedge clk);
        clr = c; id_wreg = w; id_m2reg = m; id_rn = rn;
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        #1;
        st = ref_stall(rs, rt, urs, urt);
        chk("fwda", fwda, ref_fwd(rs, urs));
        chk("fwdb", fwdb, ref_fwd(rt, urt));
        chk("pc_we", pc_we, !st);
        chk("ifid_we", ifid_we, !st);
        chk("idex_bubble", idex_bubble, st);
        chk("stall_cnt", stall_cnt, (m_stalls > 65535) ? 65535 : m_stalls);
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            if (st) m_stalls++;
            ins = st ? '{wr: 0, ld: 0, dst: 0} : '{wr: w, ld: m, dst: rn};
            hist.push_front(ins);
            void'(hist.pop_back());
        end
    endtask

    task automatic nop_cyc(input logic c);
        cycle(c, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        clr = 1; id_rs = 0; id_rt = 0; id_rn = 0;
        id_use_rs = 0; id_use_rt = 0; id_wreg = 0; id_m2reg = 0;
        nop_cyc(1);
        nop_cyc(1);
        #1;
        chk("rst_fwda", fwda, 2'b00);
        chk("rst_pc_we", pc_we, 1'b1);
        chk("rst_bubble", idex_bubble, 1'b0);
        chk("rst_cnt", stall_cnt, 16'd0);

        // add r3,r1,r2 ; sub r4,r3,r1
        cycle(0, 1, 0, 3, 1, 2, 1, 1);
        cycle(0, 1, 0, 4, 3, 1, 1, 1);
        nop_cyc(0); nop_cyc(0);

        // lw r5 ; add r6,r5,r5 (stalled once, then resolved from load data)
        cycle(0, 1, 1, 5, 0, 0, 1, 0);
        cycle(0, 1, 0, 6, 5, 5, 1, 1);
        #1;
        chk("lu_cnt_after", stall_cnt, 16'd1);
        cycle(0, 1, 0, 6, 5, 5, 1, 1);
        chk("lu_fwda_ld", fwda, 2'b11);
        nop_cyc(0); nop_cyc(0);

        // add r7 ; add r7 ; use r7 -> EX wins
        cycle(0, 1, 0, 7, 1, 1, 1, 1);
        cycle(0, 1, 0, 7, 1, 1, 1, 1);
        cycle(0, 0, 0, 0, 7, 7, 1, 1);
        chk("prio_fwda", fwda, 2'b01);
        nop_cyc(0); nop_cyc(0);

        // r0 is never a hazard, even for a load
        cycle(0, 1, 0, 0, 1, 1, 1, 1);
        cycle(0, 1, 1, 0, 0, 0, 1, 1);
        cycle(0, 1, 0, 2, 0, 0, 1, 1);
        chk("r0_pc_we", pc_we, 1'b1);
        nop_cyc(0); nop_cyc(0);

        // back-to-back load-use pairs: lw r8 ; lw r9,(r8) ; add r10,r9
        cycle(0, 1, 1, 8, 0, 0, 1, 0);
        cycle(0, 1, 1, 9, 8, 0, 1, 0);
        cycle(0, 1, 1, 9, 8, 0, 1, 0);
        cycle(0, 1, 0, 10, 9, 0, 1, 0);
        cycle(0, 1, 0, 10, 9, 0, 1, 0);
        nop_cyc(0); nop_cyc(0);

        // clear asserted during the stall cycle
        cycle(0, 1, 1, 5, 0, 0, 1, 0);
        cycle(1, 1, 0, 6, 5, 5, 1, 1);
        nop_cyc(0);
        chk("clr_cnt", stall_cnt, 16'd0);
        chk("clr_pc_we", pc_we, 1'b1);

        // random streams over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 79) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // saturation: 65537 lw/use stalls from a cleared counter
        nop_cyc(1);
        for (int i = 0; i < 65537; i++) begin
            cycle(0, 1, 1, 5, 0, 0, 0, 0);
            cycle(0, 1, 0, 6, 5, 0, 1, 0);
            cycle(0, 1, 0, 6, 5, 0, 1, 0);
        end
        nop_cyc(0);
        chk("sat_cnt", stall_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
